// File: rtl/alu_req_driver.sv
// Initiator for the combinational 8-bit add/sub ALU.
// Requests are buffered in a FIFO and issued one per cycle on registered ALU operands.
// Each ALU result is checked against a golden model and returned with its tag.
module alu_req_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_operand,
  input  logic [8:0]       alu_result,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [8:0]       rsp_result,
  output logic             rsp_overflow,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0]       mem_a   [DEPTH];
  logic [7:0]       mem_b   [DEPTH];
  logic             mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             iss_valid;
  logic [TAG_W-1:0] iss_tag;

  logic             push;
  logic             fifo_empty;
  logic             iss_load;
  logic             rsp_load;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic             full_nxt;
  logic [8:0]       exp_result;
  logic             exp_ovf;
  logic             err_nxt;

  // Handshakes, pointer next-state and golden model of the op currently on the ALU
  always_comb begin
    push       = req_valid && req_ready;
    fifo_empty = (wr_ptr == rd_ptr);
    rsp_load   = iss_valid && (!rsp_valid || rsp_ready);
    iss_load   = !fifo_empty && (!iss_valid || rsp_load);
    wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = iss_load ? rd_ptr + PW'(1) : rd_ptr;
    full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    if (alu_operand) begin
      exp_result = {1'b0, alu_a} - {1'b0, alu_b};
      exp_ovf    = 1'b0;
    end else begin
      exp_result = {1'b0, alu_a} + {1'b0, alu_b};
      exp_ovf    = exp_result[8];
    end
    err_nxt = (alu_result != exp_result) || (alu_overflow != exp_ovf);
  end

  // FIFO payload write; contents are don't-care until pointed to, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]]   <= req_a;
      mem_b[wr_ptr[AW-1:0]]   <= req_b;
      mem_op[wr_ptr[AW-1:0]]  <= req_op;
      mem_tag[wr_ptr[AW-1:0]] <= req_tag;
    end
  end

  // FIFO pointers and registered ready (depends only on occupancy)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      req_ready <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      req_ready <= !full_nxt;
    end
  end

  // Issue register: drives the ALU, holds while stalled or idle
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid   <= 1'b0;
      iss_tag     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_operand <= 1'b0;
    end else begin
      if (iss_load) begin
        iss_valid   <= 1'b1;
        iss_tag     <= mem_tag[rd_ptr[AW-1:0]];
        alu_a       <= mem_a[rd_ptr[AW-1:0]];
        alu_b       <= mem_b[rd_ptr[AW-1:0]];
        alu_operand <= mem_op[rd_ptr[AW-1:0]];
      end else if (rsp_load) begin
        iss_valid <= 1'b0;
      end
    end
  end

  // Response register and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_tag      <= '0;
      rsp_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      if (rsp_load) begin
        rsp_valid    <= 1'b1;
        rsp_result   <= alu_result;
        rsp_overflow <= alu_overflow;
        rsp_tag      <= iss_tag;
        rsp_err      <= err_nxt;
        if (err_nxt && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed bench for alu_req_driver with a behavioural ALU that can inject an ADD fault.
module tb_alu_req_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_op;
  logic [3:0] req_tag;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_operand;
  logic [8:0] alu_result;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_result;
  logic       rsp_overflow;
  logic [3:0] rsp_tag;
  logic       rsp_err;
  logic [15:0] err_count;

  logic       fault;
  logic [8:0] alu_sum;

  int passed = 0;
  int total  = 0;

  alu_req_driver #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operand(alu_operand),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Combinational ALU; fault adds 1 to ADD results
  always_comb begin
    if (alu_operand) alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
    else             alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_overflow = !alu_operand && alu_sum[8];
    alu_result   = (fault && !alu_operand) ? alu_sum + 9'd1 : alu_sum;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [3:0] tag;
    logic [8:0] res;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present one request from a negedge; returns at the negedge after acceptance
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic op, input logic [3:0] tag);
    int n;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; returns number of negedges waited
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_arrive", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int lat;
    int k;
    int got;
    int cyc;
    logic [3:0] got_tag [8];
    logic [8:0] got_res [8];
    int         got_cyc [8];

    vecs[0] = '{a: 8'd200, b: 8'd100, op: 1'b0, tag: 4'd3,  res: 9'h12C, ovf: 1'b1};
    vecs[1] = '{a: 8'd5,   b: 8'd10,  op: 1'b1, tag: 4'd4,  res: 9'h1FB, ovf: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd255, op: 1'b0, tag: 4'd5,  res: 9'h1FE, ovf: 1'b1};
    vecs[3] = '{a: 8'd0,   b: 8'd0,   op: 1'b1, tag: 4'd6,  res: 9'h000, ovf: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd255, op: 1'b1, tag: 4'd7,  res: 9'h101, ovf: 1'b0};
    vecs[5] = '{a: 8'd128, b: 8'd128, op: 1'b0, tag: 4'd8,  res: 9'h100, ovf: 1'b1};
    vecs[6] = '{a: 8'd10,  b: 8'd3,   op: 1'b1, tag: 4'd9,  res: 9'h007, ovf: 1'b0};
    vecs[7] = '{a: 8'd100, b: 8'd27,  op: 1'b0, tag: 4'd10, res: 9'h07F, ovf: 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 1'b0; req_tag = '0;
    rsp_ready = 1'b1; fault = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Table-driven single ops, latency checked on the first
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
      wait_rsp(lat);
      if (i == 0) check("latency", 32'(lat), 32'd2);
      check($sformatf("vec%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
      check($sformatf("vec%0d_ovf", i), 32'(rsp_overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_tag", i), 32'(rsp_tag), 32'(vecs[i].tag));
      check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'd0);
      @(negedge clk);
    end
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Fill with responses blocked: DEPTH+2 accepted
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 8) begin
        req_a = 8'(k); req_b = 8'd1; req_op = 1'b0; req_tag = 4'(k); req_valid = 1'b1;
        if (req_ready) k++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("fill_accepted", 32'(k), 32'd6);
    check("fill_req_ready", 32'(req_ready), 32'd0);
    check("fill_rsp_tag0", 32'(rsp_tag), 32'd0);

    // Drain in order, remaining tags pushed as space opens
    rsp_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 8 && cyc < 60) begin
      if (rsp_valid) begin
        got_tag[got] = rsp_tag; got_res[got] = rsp_result; got_cyc[got] = cyc;
        got++;
      end
      if (k < 8) begin
        req_a = 8'(k); req_b = 8'd1; req_op = 1'b0; req_tag = 4'(k); req_valid = 1'b1;
        if (req_ready) k++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("drain_count", 32'(got), 32'd8);
    for (int i = 0; i < got; i++) begin
      check($sformatf("drain%0d_tag", i), 32'(got_tag[i]), 32'(i));
      check($sformatf("drain%0d_result", i), 32'(got_res[i]), 32'(i + 1));
    end
    if (got >= 6) check("drain_back_to_back", 32'(got_cyc[5] - got_cyc[0]), 32'd5);
    @(negedge clk);

    // Faulty ADD 1+1 flagged and counted
    fault = 1'b1;
    push(8'd1, 8'd1, 1'b0, 4'd11);
    wait_rsp(lat);
    check("fault_result", 32'(rsp_result), 32'h003);
    check("fault_err", 32'(rsp_err), 32'd1);
    check("fault_count", 32'(err_count), 32'd1);
    @(negedge clk);
    // SUB unaffected by the fault
    push(8'd9, 8'd4, 1'b1, 4'd12);
    wait_rsp(lat);
    check("sub_ok_err", 32'(rsp_err), 32'd0);
    check("sub_ok_count", 32'(err_count), 32'd1);
    @(negedge clk);

    // Saturation at 16'hFFFF
    force dut.err_count = 16'hFFFE;
    #1;
    release dut.err_count;
    @(negedge clk);
    push(8'd2, 8'd3, 1'b0, 4'd13);
    wait_rsp(lat);
    check("sat_inc", 32'(err_count), 32'hFFFF);
    @(negedge clk);
    push(8'd2, 8'd3, 1'b0, 4'd14);
    wait_rsp(lat);
    check("sat_hold", 32'(err_count), 32'hFFFF);
    check("sat_err", 32'(rsp_err), 32'd1);
    @(negedge clk);
    fault = 1'b0;

    // Reset with ops in flight discards them
    rsp_ready = 1'b0;
    push(8'd1, 8'd2, 1'b0, 4'd1);
    push(8'd3, 8'd4, 1'b0, 4'd2);
    push(8'd5, 8'd6, 1'b0, 4'd3);
    check("inflight_rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("pulse_rsp_valid", 32'(rsp_valid), 32'd0);
    check("pulse_err_count", 32'(err_count), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pulse_req_ready", 32'(req_ready), 32'd1);
    lat = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid) lat++;
      @(negedge clk);
    end
    check("pulse_no_rsp", 32'(lat), 32'd0);
    push(8'd7, 8'd8, 1'b0, 4'd5);
    wait_rsp(lat);
    check("post_rst_result", 32'(rsp_result), 32'h00F);
    check("post_rst_tag", 32'(rsp_tag), 32'd5);
    check("post_rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
